// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate bounds, terminal-count pulse and sticky flags.
// Optional enable prescaler is built only when COUNTER_PRESCALE_EN is defined.
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int RST_VAL  = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic             updwn,
    input  logic             en,
    input  logic             sat_mode,
    input  logic             flag_clr,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    // Elaboration-time guard against illegal parameter combinations.
    if (WIDTH < 2 || MAX_VAL < 1 || RST_VAL < 0 || RST_VAL > MAX_VAL || PRESCALE < 1) begin : g_bad_params
        $error("updown_counter_param: illegal parameter combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             step_go;

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    // Prescaler advances only on qualifying (en=1) cycles; a load restarts it.
    always_comb begin
        presc_d = presc_q;
        if (ld_en) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign step_go = en && (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign step_go = en;
`endif

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        // A set event later in this block overrides the clear.
        ovf_d   = ovf_q & ~flag_clr;
        unf_d   = unf_q & ~flag_clr;
        if (ld_en) begin
            count_d = (datain > MAX_V) ? MAX_V : datain;
        end else if (step_go) begin
            if (updwn) begin
                if (count_q >= MAX_V) begin
                    count_d = sat_mode ? MAX_V : '0;
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = sat_mode ? '0 : MAX_V;
                    tc_d    = 1'b1;
                    unf_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RST_V;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign dataout = count_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench for updown_counter_param (MAX_VAL=9); the prescaler
// section runs only when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst_n, ld_en, updwn, en, sat_mode, flag_clr;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       tc, ovf, unf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // PRESCALE=1 keeps this instance cycle-exact whether or not the prescaler is built.
    updown_counter_param #(.WIDTH(8), .MAX_VAL(9), .RST_VAL(0), .PRESCALE(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_en    (ld_en),
        .updwn    (updwn),
        .en       (en),
        .sat_mode (sat_mode),
        .flag_clr (flag_clr),
        .datain   (datain),
        .dataout  (dataout),
        .tc       (tc),
        .ovf      (ovf),
        .unf      (unf)
    );

`ifdef COUNTER_PRESCALE_EN
    logic       rst_n_p, en_p;
    logic [7:0] dataout_p;
    logic       tc_p, ovf_p, unf_p;

    updown_counter_param #(.WIDTH(8), .MAX_VAL(9), .RST_VAL(0), .PRESCALE(4)) u_dut_p (
        .clk      (clk),
        .rst_n    (rst_n_p),
        .ld_en    (1'b0),
        .updwn    (1'b1),
        .en       (en_p),
        .sat_mode (1'b0),
        .flag_clr (1'b0),
        .datain   (8'd0),
        .dataout  (dataout_p),
        .tc       (tc_p),
        .ovf      (ovf_p),
        .unf      (unf_p)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int d, input int t, input int o, input int u);
        chk({tag, ".dataout"}, 32'(dataout), 32'(d));
        chk({tag, ".tc"},      32'(tc),      32'(t));
        chk({tag, ".ovf"},     32'(ovf),     32'(o));
        chk({tag, ".unf"},     32'(unf),     32'(u));
    endtask

    initial begin
        int exp_wrap [4] = '{8, 9, 0, 1};
        int tc_wrap  [4] = '{0, 0, 1, 0};
        int tc_sat   [3] = '{0, 1, 1};

        rst_n = 1'b0; ld_en = 1'b1; en = 1'b1; updwn = 1'b1;
        sat_mode = 1'b0; flag_clr = 1'b0; datain = 8'd5;
`ifdef COUNTER_PRESCALE_EN
        rst_n_p = 1'b0; en_p = 1'b0;
`endif
        #2;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0);

        rst_n = 1'b1; ld_en = 1'b0;
        tick();
        chk_all("first_step", 1, 0, 0, 0);

        // Wrap up against MAX_VAL=9
        ld_en = 1'b1; en = 1'b0; datain = 8'd7;
        tick();
        chk_all("load7", 7, 0, 0, 0);
        ld_en = 1'b0; en = 1'b1; updwn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("wrap_up%0d", i), exp_wrap[i], tc_wrap[i], (i >= 2) ? 1 : 0, 0);
        end

        en = 1'b0;
        tick();
        chk_all("hold", 1, 0, 1, 0);

        // Saturate down from 1
        sat_mode = 1'b1; ld_en = 1'b1; datain = 8'd1;
        tick();
        chk_all("load1", 1, 0, 1, 0);
        ld_en = 1'b0; en = 1'b1; updwn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("sat_down%0d", i), 0, tc_sat[i], 1, (i >= 1) ? 1 : 0);
        end
        en = 1'b0; flag_clr = 1'b1;
        tick();
        chk_all("flag_clr", 0, 0, 0, 0);

        // Load clamp wins over en
        flag_clr = 1'b0; ld_en = 1'b1; en = 1'b1; datain = 8'd200;
        tick();
        chk_all("load_clamp", 9, 0, 0, 0);
        ld_en = 1'b0; sat_mode = 1'b0; updwn = 1'b1;
        tick();
        chk_all("wrap_after_clamp", 0, 1, 1, 0);

        // Set beats clear on the same edge; ovf has no set so it clears
        updwn = 1'b0; flag_clr = 1'b1;
        tick();
        chk_all("clr_vs_set", 9, 1, 0, 1);

        flag_clr = 1'b0; sat_mode = 1'b1; updwn = 1'b1;
        tick();
        chk_all("sat_up_max", 9, 1, 1, 1);
        sat_mode = 1'b0; updwn = 1'b0;
        tick();
        chk_all("down_mid", 8, 0, 1, 1);

        rst_n = 1'b0;
        tick();
        chk_all("reset_mid", 0, 0, 0, 0);
        rst_n = 1'b1; en = 1'b0;

`ifdef COUNTER_PRESCALE_EN
        begin
            // en pattern with a 2-cycle gap; the step lands 2 cycles late
            logic en_vec [12] = '{1,1,1,1, 1,1,0,0, 1,1,1,1};
            int   cnt_vec[12] = '{0,0,0,1, 1,1,1,1, 1,2,2,2};
            tick();
            rst_n_p = 1'b1;
            for (int i = 0; i < 12; i++) begin
                en_p = en_vec[i];
                tick();
                chk($sformatf("presc%0d", i), 32'(dataout_p), 32'(cnt_vec[i]));
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
